// File: rtl/ps2_kbd_ctrl_pkg.sv
// Shared constants and types for the PS/2 keyboard front-end.
// Prefix bytes, event field positions and frame FSM encoding.
package ps2_kbd_ctrl_pkg;

  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

  localparam int unsigned EV_EXT = 9;
  localparam int unsigned EV_BRK = 8;
  localparam int unsigned EV_W   = 10;

  // Start bit is consumed in StIdle, so there is no separate start state.
  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } frame_state_e;

endpackage

// File: rtl/ps2_kbd_ctrl_filter.sv
// Two-flop synchroniser followed by a stability counter for one PS/2 line.
// The output only follows the input once it has held steady for FILT_LEN samples.
module ps2_kbd_ctrl_filter #(
  parameter int unsigned FILT_LEN = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int unsigned CW = $clog2(FILT_LEN + 1);
  localparam logic [CW-1:0] CntMax = CW'(FILT_LEN - 1);

  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      dout    <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      if (sync2_q == dout) begin
        cnt_q <= '0;
      end else if (cnt_q == CntMax) begin
        dout  <= sync2_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard front-end: filtered pins, frame sequencer with watchdog,
// E0/F0 prefix collapsing and a small event FIFO with a valid/ready pop port.
module ps2_kbd_ctrl
  import ps2_kbd_ctrl_pkg::*;
#(
  parameter int unsigned FILT_LEN    = 20,
  parameter int unsigned TIMEOUT_CYC = 200000,
  parameter int unsigned FIFO_AW     = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            kclk,
  input  logic            kdata,
  output logic [EV_W-1:0] ev_data,
  output logic            ev_valid,
  input  logic            ev_ready,
  output logic            err_parity,
  output logic            err_timeout,
  output logic            err_overflow,
  input  logic            err_clear
);

  localparam int unsigned DEPTH = 2 ** FIFO_AW;
  localparam int unsigned WW    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WW-1:0]      WdMax = WW'(TIMEOUT_CYC);
  localparam logic [FIFO_AW:0]   CntFull = (FIFO_AW + 1)'(DEPTH);

  logic kclk_f, kdata_f, kclk_prev_q, fall;

  ps2_kbd_ctrl_filter #(.FILT_LEN(FILT_LEN)) u_filt_clk (
    .clk  (clk),
    .rst  (rst),
    .din  (kclk),
    .dout (kclk_f)
  );

  ps2_kbd_ctrl_filter #(.FILT_LEN(FILT_LEN)) u_filt_data (
    .clk  (clk),
    .rst  (rst),
    .din  (kdata),
    .dout (kdata_f)
  );

  assign fall = kclk_prev_q & ~kclk_f;

  frame_state_e  state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_q, par_d;
  logic          byte_valid_q, byte_valid_d;
  logic [WW-1:0] wd_q, wd_d;
  logic          frame_bad, timeout;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    par_d        = par_q;
    byte_valid_d = 1'b0;
    frame_bad    = 1'b0;
    timeout      = 1'b0;
    wd_d         = (state_q == StIdle || fall) ? '0 : wd_q + 1'b1;
    if (state_q != StIdle && !fall && wd_q == WdMax) begin
      timeout = 1'b1;
      state_d = StIdle;
      wd_d    = '0;
    end else if (fall) begin
      unique case (state_q)
        StIdle: begin
          if (!kdata_f) begin
            state_d   = StData;
            bit_cnt_d = '0;
          end
        end
        StData: begin
          shreg_d   = {kdata_f, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = StParity;
        end
        StParity: begin
          par_d   = kdata_f;
          state_d = StStop;
        end
        StStop: begin
          state_d = StIdle;
          if (kdata_f && (^{shreg_q, par_q})) byte_valid_d = 1'b1;
          else                                frame_bad    = 1'b1;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      par_q        <= 1'b0;
      byte_valid_q <= 1'b0;
      wd_q         <= '0;
      kclk_prev_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      par_q        <= par_d;
      byte_valid_q <= byte_valid_d;
      wd_q         <= wd_d;
      kclk_prev_q  <= kclk_f;
    end
  end

  // shreg_q stays stable for the cycle after the stop strobe, so it doubles as the byte.
  logic             ext_q, brk_q;
  logic             is_pfx, push_req, push, pop, full;
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   count_q;
  logic [EV_W-1:0]    mem [DEPTH];

  assign is_pfx   = (shreg_q == PS2_PFX_EXT) || (shreg_q == PS2_PFX_BRK);
  assign push_req = byte_valid_q && !is_pfx;
  assign full     = (count_q == CntFull);
  assign ev_valid = (count_q != '0);
  assign pop      = ev_valid && ev_ready;
  assign push     = push_req && (!full || pop);
  assign ev_data  = ev_valid ? mem[rd_ptr_q] : '0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {ext_q, brk_q, shreg_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      err_parity   <= 1'b0;
      err_timeout  <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      if (timeout || frame_bad) begin
        ext_q <= 1'b0;
        brk_q <= 1'b0;
      end else if (byte_valid_q) begin
        if (shreg_q == PS2_PFX_EXT) begin
          ext_q <= 1'b1;
        end else if (shreg_q == PS2_PFX_BRK) begin
          brk_q <= 1'b1;
        end else begin
          ext_q <= 1'b0;
          brk_q <= 1'b0;
        end
      end
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (err_clear) begin
        err_parity   <= 1'b0;
        err_timeout  <= 1'b0;
        err_overflow <= 1'b0;
      end else begin
        if (frame_bad)           err_parity   <= 1'b1;
        if (timeout)             err_timeout  <= 1'b1;
        if (push_req && !push)   err_overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Scoreboard bench for ps2_kbd_ctrl: PS/2 frames are bit-banged on the pins and
// expected events are queued by a small model, then compared as the FIFO is popped.
module tb_ps2_kbd_ctrl;
  import ps2_kbd_ctrl_pkg::*;

  localparam int FL = 4;
  localparam int TO = 2000;
  localparam int AW = 3;
  localparam int DEPTH = 8;
  localparam int H = 12;

  logic       clk = 1'b0;
  logic       rst, kclk, kdata, ev_ready, err_clear;
  logic [9:0] ev_data;
  logic       ev_valid, err_parity, err_timeout, err_overflow;

  ps2_kbd_ctrl #(.FILT_LEN(FL), .TIMEOUT_CYC(TO), .FIFO_AW(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .kclk         (kclk),
    .kdata        (kdata),
    .ev_data      (ev_data),
    .ev_valid     (ev_valid),
    .ev_ready     (ev_ready),
    .err_parity   (err_parity),
    .err_timeout  (err_timeout),
    .err_overflow (err_overflow),
    .err_clear    (err_clear)
  );

  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  logic [9:0] exp_q[$];
  logic       m_ext = 1'b0, m_brk = 1'b0, m_ovf = 1'b0;

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    kdata = b;
    wait_cyc(H);
    kclk = 1'b0;
    wait_cyc(H);
    kclk = 1'b1;
  endtask

  // Sends the first nbits of an 11-bit frame; flip inverts the parity bit.
  task automatic send_bits(input logic [7:0] b, input int nbits, input logic flip);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ flip, b, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(f[i]);
    kdata = 1'b1;
    wait_cyc(H);
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      if (exp_q.size() < DEPTH) exp_q.push_back({m_ext, m_brk, b});
      else m_ovf = 1'b1;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic key(input logic [7:0] b);
    send_bits(b, 11, 1'b0);
    model_byte(b);
  endtask

  task automatic pop_check(input string name);
    logic [9:0] e;
    int n;
    n = 0;
    while (!ev_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 10'h3FF;
    if (!ev_valid) begin
      errors++;
      $display("FAIL %s: ev_valid never rose, expected ev_data=%h", name, e);
    end else if (ev_data !== e) begin
      errors++;
      $display("FAIL %s: ev_data=%h expected %h", name, ev_data, e);
    end
    if (ev_valid) begin
      ev_ready = 1'b1;
      @(negedge clk);
      ev_ready = 1'b0;
    end
  endtask

  task automatic wait_fall(input string name);
    int n;
    n = 0;
    while (!dut.fall && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!dut.fall) begin
      errors++;
      $display("FAIL %s: no filtered kclk fall seen, got 0 expected 1", name);
    end
  endtask

  task automatic clear_errs();
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    m_ovf = 1'b0;
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if (ev_valid !== 1'b0 || ev_data !== 10'h000 || err_parity !== 1'b0 ||
        err_timeout !== 1'b0 || err_overflow !== 1'b0 || dut.state_q !== StIdle) begin
      errors++;
      $display("FAIL %s: v=%b d=%h ep=%b et=%b eo=%b st=%0d expected all 0 / idle",
               name, ev_valid, ev_data, err_parity, err_timeout, err_overflow, dut.state_q);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_cyc(4);
    check_idle_outputs("reset_state");
    rst = 1'b0;
    wait_cyc(4);
    check_idle_outputs("after_reset_release");
  endtask

  task automatic test_single();
    send_bits(8'h1C, 10, 1'b0);
    model_byte(8'h1C);
    kdata = 1'b1;
    wait_cyc(H);
    kclk = 1'b0;
    wait_fall("single_stop_fall");
    @(negedge clk);
    checks++;
    if (ev_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_n1: ev_valid=%b expected 0", ev_valid);
    end
    @(negedge clk);
    checks++;
    if (ev_valid !== 1'b1 || ev_data !== 10'h01C) begin
      errors++;
      $display("FAIL latency_n2: ev_valid=%b ev_data=%h expected 1 01c", ev_valid, ev_data);
    end
    wait_cyc(H);
    kclk = 1'b1;
    wait_cyc(H);
    pop_check("single_1c");
  endtask

  task automatic test_prefix();
    key(8'hE0);
    key(8'hF0);
    key(8'h75);
    wait_cyc(10);
    pop_check("prefix_375");
    wait_cyc(4);
    checks++;
    if (ev_valid !== 1'b0) begin
      errors++;
      $display("FAIL prefix_single_event: ev_valid=%b expected 0", ev_valid);
    end
    key(8'h75);
    pop_check("prefix_flags_cleared");
  endtask

  task automatic test_parity();
    send_bits(8'h1C, 11, 1'b1);
    m_ext = 1'b0;
    m_brk = 1'b0;
    wait_cyc(10);
    checks++;
    if (ev_valid !== 1'b0 || err_parity !== 1'b1) begin
      errors++;
      $display("FAIL parity_drop: ev_valid=%b err_parity=%b expected 0 1", ev_valid, err_parity);
    end
    clear_errs();
    checks++;
    if (err_parity !== 1'b0) begin
      errors++;
      $display("FAIL parity_clear: err_parity=%b expected 0", err_parity);
    end
  endtask

  task automatic test_timeout();
    send_bits(8'h55, 6, 1'b0);
    wait_cyc(TO + 50);
    m_ext = 1'b0;
    m_brk = 1'b0;
    checks++;
    if (err_timeout !== 1'b1 || dut.state_q !== StIdle || ev_valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_abort: err_timeout=%b state=%0d ev_valid=%b expected 1 0 0",
               err_timeout, dut.state_q, ev_valid);
    end
    key(8'h29);
    pop_check("timeout_recover_29");
    clear_errs();
    checks++;
    if (err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear: err_timeout=%b expected 0", err_timeout);
    end
  endtask

  task automatic test_overflow();
    for (int b = 8'h16; b <= 8'h1E; b++) key(8'(b));
    wait_cyc(10);
    checks++;
    if (err_overflow !== m_ovf || m_ovf !== 1'b1) begin
      errors++;
      $display("FAIL overflow_flag: err_overflow=%b expected 1", err_overflow);
    end
    for (int i = 0; i < DEPTH; i++) pop_check("overflow_drain");
    wait_cyc(4);
    checks++;
    if (ev_valid !== 1'b0) begin
      errors++;
      $display("FAIL overflow_empty: ev_valid=%b expected 0", ev_valid);
    end
    clear_errs();
  endtask

  task automatic test_back_to_back();
    logic [9:0] e;
    for (int b = 8'h30; b <= 8'h37; b++) key(8'(b));
    wait_cyc(4);
    checks++;
    if (dut.count_q !== 4'(DEPTH) || err_overflow !== 1'b0) begin
      errors++;
      $display("FAIL b2b_full: count=%0d err_overflow=%b expected 8 0", dut.count_q, err_overflow);
    end
    send_bits(8'h38, 10, 1'b0);
    kdata = 1'b1;
    wait_cyc(H);
    kclk = 1'b0;
    wait_fall("b2b_stop_fall");
    @(negedge clk);
    ev_ready = 1'b1;
    e = exp_q.pop_front();
    checks++;
    if (ev_data !== e) begin
      errors++;
      $display("FAIL b2b_pop_head: ev_data=%h expected %h", ev_data, e);
    end
    @(negedge clk);
    ev_ready = 1'b0;
    model_byte(8'h38);
    checks++;
    if (dut.count_q !== 4'(DEPTH) || err_overflow !== 1'b0) begin
      errors++;
      $display("FAIL b2b_count: count=%0d err_overflow=%b expected 8 0", dut.count_q, err_overflow);
    end
    wait_cyc(H);
    kclk = 1'b1;
    wait_cyc(H);
    for (int i = 0; i < DEPTH; i++) pop_check("b2b_drain");
  endtask

  task automatic test_reset_mid();
    key(8'h44);
    wait_cyc(10);
    send_bits(8'h12, 4, 1'b0);
    rst = 1'b1;
    wait_cyc(3);
    check_idle_outputs("reset_mid_frame");
    exp_q.delete();
    m_ext = 1'b0;
    m_brk = 1'b0;
    m_ovf = 1'b0;
    rst = 1'b0;
    wait_cyc(20);
    key(8'h1C);
    pop_check("reset_fresh_1c");
    wait_cyc(4);
    checks++;
    if (ev_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_only_one: ev_valid=%b expected 0", ev_valid);
    end
  endtask

  initial begin
    rst = 1'b1;
    kclk = 1'b1;
    kdata = 1'b1;
    ev_ready = 1'b0;
    err_clear = 1'b0;
    test_reset();
    test_single();
    test_prefix();
    test_parity();
    test_timeout();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "bench time limit");
  end

endmodule
